// File: rtl/alu_acumulador_banco.sv
// WIDTH-bit ALU over a bank of accumulators with registered carry/zero/overflow,
// optional saturating add, shift ops and a multi-cycle shift-add multiplier.
//
// state  | meaning
// S_IDLE | single-cycle ops execute on en_acu; 111 captures operands and starts a multiply
// S_MUL  | one shift-add step per cycle; write-back and flags on the last step
module alu_acumulador_banco #(
  parameter int WIDTH    = 4,
  parameter int NUM_ACC  = 4,
  parameter int SEL_BITS = 2,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_bus1,
  input  logic                en_bus2,
  input  logic                en_acu,
  input  logic [2:0]          selct,
  input  logic [SEL_BITS-1:0] acc_sel,
  input  logic [WIDTH-1:0]    d,
  output logic [WIDTH-1:0]    salida,
  output logic                carry,
  output logic                zero,
  output logic                overflow,
  output logic                busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      acc_q [NUM_ACC];
  logic                  carry_q, carry_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;
  logic [SEL_BITS-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic [2*WIDTH-1:0]    mcand_q, mcand_d;
  logic [2*WIDTH-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]      op_a, op_b, alu_res, wr_val;
  logic [WIDTH:0]        sum, diff;
  logic [2*WIDTH-1:0]    prod_step;
  logic                  alu_c, alu_ovf, alu_wr, wr_en;
  logic [SEL_BITS-1:0]   wr_sel;

  always_comb begin
    op_a    = acc_q[acc_sel];
    op_b    = en_bus1 ? d : '0;
    sum     = {1'b0, op_a} + {1'b0, op_b};
    diff    = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
    alu_res = op_a;
    alu_c   = 1'b0;
    alu_ovf = 1'b0;
    alu_wr  = 1'b1;
    case (selct)
      3'b000: alu_res = op_a;
      3'b001: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        alu_wr  = 1'b0;
      end
      3'b010: alu_res = op_b;
      3'b011: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        // Flags keep the raw sum; only the written value (and zero) see the clamp.
        if ((SATURATE != 0) && sum[WIDTH]) alu_res = '1;
      end
      3'b100: alu_res = ~(op_a & op_b);
      3'b101: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
      end
      3'b110: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      default: alu_wr = 1'b0;
    endcase
  end

  always_comb begin
    prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    state_d   = state_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    sel_d     = sel_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_sel    = acc_sel;
    wr_val    = alu_res;
    case (state_q)
      S_IDLE: begin
        if (en_acu) begin
          if (selct == 3'b111) begin
            state_d  = S_MUL;
            sel_d    = acc_sel;
            mplier_d = op_b;
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            prod_d   = '0;
            cnt_d    = CNT_W'(WIDTH-1);
          end else begin
            wr_en   = alu_wr;
            carry_d = alu_c;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_ovf;
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_step;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          wr_en   = 1'b1;
          wr_sel  = sel_q;
          wr_val  = prod_step[WIDTH-1:0];
          carry_d = |prod_step[2*WIDTH-1:WIDTH];
          zero_d  = (prod_step[WIDTH-1:0] == '0);
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sel_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      sel_q    <= sel_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      if (wr_en) acc_q[wr_sel] <= wr_val;
    end
  end

  assign salida   = en_bus2 ? acc_q[acc_sel] : {WIDTH{1'bz}};
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_acumulador_banco.sv
// Bench for alu_acumulador_banco: wrapping and saturating instances share stimulus;
// directed vector table plus hand-written multiply and reset sequences.
module tb_alu_acumulador_banco;

  logic       clk, reset, en_bus1, en_bus2, en_acu;
  logic [2:0] selct;
  logic [1:0] acc_sel;
  logic [3:0] d;
  wire  [3:0] salida, salida_s;
  logic       carry, zero, overflow, busy;
  logic       carry_s, zero_s, overflow_s, busy_s;

  int checks = 0;
  int failures = 0;

  alu_acumulador_banco #(.WIDTH(4), .NUM_ACC(4), .SEL_BITS(2), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .en_bus1(en_bus1), .en_bus2(en_bus2), .en_acu(en_acu),
    .selct(selct), .acc_sel(acc_sel), .d(d), .salida(salida), .carry(carry),
    .zero(zero), .overflow(overflow), .busy(busy));

  alu_acumulador_banco #(.WIDTH(4), .NUM_ACC(4), .SEL_BITS(2), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en_bus1(en_bus1), .en_bus2(en_bus2), .en_acu(en_acu),
    .selct(selct), .acc_sel(acc_sel), .d(d), .salida(salida_s), .carry(carry_s),
    .zero(zero_s), .overflow(overflow_s), .busy(busy_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       eb1;
    logic       acu;
    logic [2:0] op;
    logic [1:0] sel;
    logic [3:0] dv;
    logic [3:0] acc;
    logic       c;
    logic       z;
    logic       o;
    logic [3:0] acc_s;
    logic       z_s;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic eb1, input logic acu, input logic [2:0] op,
                       input logic [1:0] sel, input logic [3:0] dv);
    en_bus1 = eb1;
    en_acu  = acu;
    selct   = op;
    acc_sel = sel;
    d       = dv;
    @(negedge clk);
    en_acu  = 1'b0;
  endtask

  task automatic run_mul(input logic [1:0] sel, input logic [3:0] dv, output int nbusy);
    drive(1'b1, 1'b1, 3'b111, sel, dv);
    en_acu  = 1'b1;
    selct   = 3'b010;
    acc_sel = sel + 2'd1;
    d       = 4'b1111;
    nbusy   = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      nbusy++;
      @(negedge clk);
    end
    en_acu  = 1'b0;
    acc_sel = sel;
    #1;
  endtask

  initial begin
    int nb;
    vt[0]  = '{1'b1, 1'b1, 3'b010, 2'd0, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 3'b011, 2'd0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 3'b010, 2'd1, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 3'b001, 2'd1, 4'b0111, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 3'b001, 2'd1, 4'b0101, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 3'b010, 2'd0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 3'b010, 2'd3, 4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 3'b101, 2'd3, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 3'b110, 2'd3, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 3'b100, 2'd0, 4'b0011, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b0};
    vt[10] = '{1'b1, 1'b1, 3'b000, 2'd0, 4'b0000, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b0};
    vt[11] = '{1'b1, 1'b1, 3'b011, 2'd1, 4'b0011, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0};
    vt[12] = '{1'b1, 1'b1, 3'b001, 2'd0, 4'b0111, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b1110, 1'b0};
    vt[13] = '{1'b0, 1'b1, 3'b010, 2'd3, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1};
    vt[14] = '{1'b1, 1'b1, 3'b011, 2'd0, 4'b0011, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0};
    vt[15] = '{1'b1, 1'b0, 3'b011, 2'd1, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0};

    reset = 1'b0; en_bus1 = 1'b1; en_bus2 = 1'b1; en_acu = 1'b0;
    selct = 3'b000; acc_sel = 2'd0; d = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_salida", salida, 4'b0000);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_busy_s", busy_s, 1'b0);

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].eb1, vt[i].acu, vt[i].op, vt[i].sel, vt[i].dv);
      chk($sformatf("row%0d_acc", i), salida, vt[i].acc);
      chk($sformatf("row%0d_carry", i), carry, vt[i].c);
      chk($sformatf("row%0d_zero", i), zero, vt[i].z);
      chk($sformatf("row%0d_ovf", i), overflow, vt[i].o);
      chk($sformatf("row%0d_acc_sat", i), salida_s, vt[i].acc_s);
      chk($sformatf("row%0d_carry_sat", i), carry_s, vt[i].c);
      chk($sformatf("row%0d_zero_sat", i), zero_s, vt[i].z_s);
      chk($sformatf("row%0d_ovf_sat", i), overflow_s, vt[i].o);
      if (i == 6) begin
        acc_sel = 2'd0;
        #1 chk("follow_acc0", salida, 4'b0001);
        acc_sel = 2'd3;
        #1 chk("follow_acc3", salida, 4'b1001);
        en_bus2 = 1'b0;
        #1 chk("salida_hiz", ((salida === 4'bzzzz) || (salida === 4'b0000)) ? 8'd1 : 8'd0, 8'd1);
        en_bus2 = 1'b1;
        #1 chk("salida_restore", salida, 4'b1001);
      end
    end

    drive(1'b1, 1'b1, 3'b010, 2'd2, 4'b0011);
    run_mul(2'd2, 4'b0101, nb);
    chk("mul1_busy_cycles", 8'(nb), 8'd4);
    chk("mul1_acc", salida, 4'b1111);
    chk("mul1_acc_sat", salida_s, 4'b1111);
    chk("mul1_carry", carry, 1'b0);
    chk("mul1_zero", zero, 1'b0);
    chk("mul1_ovf", overflow, 1'b0);
    acc_sel = 2'd3;
    #1 chk("mul1_acc3_untouched", salida, 4'b0000);

    drive(1'b1, 1'b1, 3'b010, 2'd2, 4'b0101);
    run_mul(2'd2, 4'b0100, nb);
    chk("mul2_busy_cycles", 8'(nb), 8'd4);
    chk("mul2_acc", salida, 4'b0100);
    chk("mul2_carry", carry, 1'b1);
    chk("mul2_zero", zero, 1'b0);
    acc_sel = 2'd3;
    #1 chk("mul2_acc3_untouched", salida, 4'b0000);

    run_mul(2'd2, 4'b0000, nb);
    chk("mul0_busy_cycles", 8'(nb), 8'd4);
    chk("mul0_acc", salida, 4'b0000);
    chk("mul0_carry", carry, 1'b0);
    chk("mul0_zero", zero, 1'b1);

    drive(1'b1, 1'b1, 3'b010, 2'd1, 4'b0111);
    drive(1'b1, 1'b1, 3'b001, 2'd1, 4'b0111);
    chk("pre_rst_carry", carry, 1'b1);
    drive(1'b1, 1'b1, 3'b111, 2'd1, 4'b0011);
    chk("midmul_busy", busy, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_carry", carry, 1'b0);
    chk("midrst_zero", zero, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    for (int a = 0; a < 4; a++) begin
      acc_sel = 2'(a);
      #1 chk($sformatf("midrst_acc%0d", a), salida, 4'b0000);
    end
    @(negedge clk);
    reset = 1'b1;
    acc_sel = 2'd1;
    repeat (8) @(negedge clk);
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_acc1", salida, 4'b0000);
    chk("postrst_acc1_sat", salida_s, 4'b0000);
    chk("postrst_zero", zero, 1'b0);
    chk("postrst_carry", carry, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_acumulador_banco.md
Name: alu_acumulador_banco

Overview:
- Parametrised successor to the 4-bit bus/accumulator ALU exercise.
- WIDTH-bit ALU with a bank of NUM_ACC accumulators and registered carry/zero/overflow flags.
- Adds optional saturating arithmetic, shift ops and a multi-cycle shift-add multiplier with a busy indication.
- Sits between the input data bus (d, gated by en_bus1) and the shared output bus (salida, tristated by en_bus2).

Parameters:
- WIDTH, 4, datapath/accumulator width in bits (>=2).
- NUM_ACC, 4, number of accumulators in the bank (power of 2, >=2).
- SEL_BITS, 2, accumulator select width; must equal log2(NUM_ACC).
- SATURATE, 0, 1 = add/subtract clamp instead of wrapping.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en_bus1  input  1  input buffer enable; 1 = d drives the B operand, 0 = B operand reads all-zero.
- en_bus2  input  1  output buffer enable; 1 = salida driven, 0 = salida high-Z.
- en_acu  input  1  commit strobe; sampled on clk rising edge.
- selct  input  3  operation select.
- acc_sel  input  SEL_BITS  selects accumulator A operand / destination.
- d  input  WIDTH  data input bus.
- salida  output  WIDTH  acc[acc_sel] when en_bus2=1, else all Z; combinational.
- carry  output  1  registered carry/no-borrow flag.
- zero  output  1  registered zero flag.
- overflow  output  1  registered signed-overflow flag.
- busy  output  1  1 while a multiply is in progress.

Behaviour:
- Reset (reset=0, async):
  - all accumulators = 0; carry = zero = overflow = 0; busy = 0; FSM -> IDLE.
  - Overrides any in-flight multiply; no partial write-back.
- Operands: A = acc[acc_sel], B = en_bus1 ? d : 0.
- Ops (selct):
  - 000 pass A
  - 001 compare A-B: flags only, no accumulator write
  - 010 load B
  - 011 A+B
  - 100 NAND
  - 101 A<<1, carry = A[WIDTH-1]
  - 110 A>>1 logical, carry = A[0]
  - 111 multiply A*B (unsigned)
- Add: carry = bit WIDTH of the (WIDTH+1)-bit sum.
- Subtract/compare: computed as A + ~B + 1; carry = 1 iff A>=B unsigned.
- overflow: signed overflow for add and subtract; 0 for all other ops.
- SATURATE=1:
  - add with carry=1 writes all ones.
  - subtract with A<B writes 0 (compare only, since 001 never writes).
  - Flags still reflect the raw, unclamped result, except zero, which reflects the written value.
- zero = (result == 0), where result is the value written; for 001 it is the raw difference.
- Single-cycle ops: on the rising edge with en_acu=1 and busy=0:
  - acc[acc_sel] <= result (except 001).
  - All three flags update.
- en_acu=0: no state change.
- Multiply FSM, states IDLE -> MUL -> IDLE:
  - IDLE: on en_acu=1 with selct=111, capture A, B and acc_sel; busy=1 from the next edge; iteration count = 0.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the edge completing step WIDTH:
    - acc[captured sel] <= product[WIDTH-1:0]
    - carry = |product[2*WIDTH-1:WIDTH]
    - zero = (written value == 0)
    - overflow = 0
    - busy -> 0
  - Total latency: WIDTH+1 edges from the start edge to write-back. A new command may start on the edge after busy falls.
- While busy=1:
  - en_acu, selct, d, acc_sel and en_bus1 are ignored; no other accumulator writes.
  - salida still reads acc[acc_sel] (live acc_sel).
- Multiply by 0: runs full latency; result 0, zero=1.
- Wrap-around: with SATURATE=0, add and subtract wrap modulo 2^WIDTH.
- en_bus2 toggles have no effect on state.

Test Plan:
- Reset, then en_bus2=1, acc_sel=0 -> salida=0000, carry=0, zero=0, overflow=0, busy=0; en_bus2=0 -> salida=zzzz.
- WIDTH=4, SATURATE=0: load d=1000 (010), then add d=1000 (011) -> acc0=0000, carry=1, zero=1, overflow=1; same sequence with SATURATE=1 -> acc0=1111, carry=1, zero=0.
- Load acc1=0101, then compare with d=0111 (001) -> acc1 stays 0101, carry=0, zero=0; compare with d=0101 -> carry=1, zero=1.
- Load acc2=0011, multiply by d=0101 (111) -> busy high for 4 cycles, then acc2=1111, carry=0. Repeat with 0101*0100 -> acc2=0100, carry=1. Commands issued during busy do not alter any accumulator.
- Start a multiply, assert reset=0 after 2 cycles -> busy=0, all accumulators and flags 0 immediately; no later write-back.
- Load acc0=0001 and acc3=1001, switch acc_sel -> salida follows the selected accumulator. Shift-left acc3 -> 0010, carry=1. en_bus1=0 with op 010 -> acc=0000, zero=1.
